// File: rtl/rst_collect_pkg.sv
// Shared types and widths for the reset request collector.
package rst_collect_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ASSERT  = 3'd1,
    HOLD    = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Width of the episode event counter.
  localparam int EVT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up on inc, hold once every bit is set.
  always_ff @(posedge clock) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/reset_request_collector.sv
// Merges per-sink reset requests into one stretched reset episode, then
// releases the sinks one at a time in ascending index order.
module reset_request_collector
  import rst_collect_pkg::*;
#(
  parameter int N_SINKS        = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_SINKS-1:0] req,
  output logic [N_SINKS-1:0] out_reset,
  output logic               busy,
  output logic               done,
  output logic [EVT_W-1:0]   event_count
);

  localparam int CNT_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (N_SINKS > 1) ? $clog2(N_SINKS) : 1;

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_SINKS - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             any_req;
  logic             evt_inc;

  assign any_req = |req;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  // Only request-driven entries into ASSERT count; the power-on entry does not.
  assign evt_inc = any_req && !reset &&
                   ((state == IDLE) || (state == DONE) || (state == RELEASE));

  // Episode sequencer: stretch, hold while requested, staggered release.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ASSERT;
      cnt       <= '0;
      idx       <= '0;
      out_reset <= '1;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ASSERT;
            cnt       <= '0;
            out_reset <= '1;
          end else begin
            out_reset <= '0;
          end
        end
        ASSERT: begin
          // Requests here are absorbed by HOLD; the stretch count is not restarted.
          out_reset <= '1;
          if (cnt == STRETCH_LAST) begin
            cnt   <= '0;
            state <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          out_reset <= '1;
          if (!any_req) begin
            state <= RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        RELEASE: begin
          // A new request aborts the release and wins over a coincident release tick.
          if (any_req) begin
            state     <= ASSERT;
            cnt       <= '0;
            out_reset <= '1;
          end else if (cnt == STAGGER_LAST) begin
            out_reset[idx] <= 1'b0;
            cnt            <= '0;
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (any_req) begin
            state     <= ASSERT;
            cnt       <= '0;
            out_reset <= '1;
          end else begin
            state     <= IDLE;
            out_reset <= '0;
          end
        end
        default: begin
          state     <= ASSERT;
          cnt       <= '0;
          idx       <= '0;
          out_reset <= '1;
        end
      endcase
    end
  end

  sat_counter #(
    .W(EVT_W)
  ) u_evt_cnt (
    .clock (clock),
    .clr   (reset),
    .inc   (evt_inc),
    .q     (event_count)
  );

endmodule

// File: tb/tb_reset_request_collector.sv
// Directed bench for reset_request_collector (N_SINKS=2, STRETCH=16, STAGGER=4).
module tb_reset_request_collector;

  logic       clock;
  logic       reset;
  logic [1:0] req;
  logic [1:0] out_reset;
  logic       busy;
  logic       done;
  logic [7:0] event_count;

  int n_vec;
  int n_mis;
  int exp_evt;

  reset_request_collector #(
    .N_SINKS       (2),
    .STRETCH_CYCLES(16),
    .STAGGER_CYCLES(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .out_reset   (out_reset),
    .busy        (busy),
    .done        (done),
    .event_count (event_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bump_evt();
    exp_evt = (exp_evt < 255) ? exp_evt + 1 : 255;
  endtask

  // From the first ASSERT cycle (cnt=0) up to and including the HOLD cycle.
  task automatic stretch_seq(input string tag);
    for (int k = 0; k <= 16; k++) begin
      check({tag, "_str_out"}, 32'(out_reset), 32'h3);
      check({tag, "_str_busy"}, 32'(busy), 32'h1);
      check({tag, "_str_done"}, 32'(done), 32'h0);
      if (k < 16) tick();
    end
    check({tag, "_str_evt"}, 32'(event_count), 32'(exp_evt));
  endtask

  // From a HOLD cycle with req=0: staggered release, DONE, then IDLE or re-request.
  task automatic release_seq(input string tag, input bit rereq);
    logic [1:0] eo;
    for (int k = 1; k <= 9; k++) begin
      tick();
      eo = (k <= 4) ? 2'b11 : (k <= 8) ? 2'b10 : 2'b00;
      check({tag, "_rel_out"}, 32'(out_reset), 32'(eo));
      check({tag, "_rel_done"}, 32'(done), (k == 9) ? 32'h1 : 32'h0);
      check({tag, "_rel_busy"}, 32'(busy), 32'h1);
    end
    if (rereq) begin
      req = 2'b01;
      tick();
      bump_evt();
      req = 2'b00;
      check({tag, "_rrq_out"}, 32'(out_reset), 32'h3);
      check({tag, "_rrq_busy"}, 32'(busy), 32'h1);
      check({tag, "_rrq_done"}, 32'(done), 32'h0);
      check({tag, "_rrq_evt"}, 32'(event_count), 32'(exp_evt));
    end else begin
      tick();
      check({tag, "_idle_busy"}, 32'(busy), 32'h0);
      check({tag, "_idle_done"}, 32'(done), 32'h0);
      check({tag, "_idle_out"}, 32'(out_reset), 32'h0);
      check({tag, "_idle_evt"}, 32'(event_count), 32'(exp_evt));
    end
  endtask

  initial begin
    n_vec   = 0;
    n_mis   = 0;
    exp_evt = 0;
    reset   = 1'b1;
    req     = 2'b00;

    // Power-on sequence.
    repeat (3) tick();
    check("rst_out", 32'(out_reset), 32'h3);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    check("rst_evt", 32'(event_count), 32'h0);
    reset = 1'b0;
    stretch_seq("por");
    release_seq("por", 1'b0);

    // Single one-cycle request from IDLE.
    req = 2'b01;
    tick();
    req = 2'b00;
    bump_evt();
    check("sgl_lat_out", 32'(out_reset), 32'h3);
    stretch_seq("sgl");
    release_seq("sgl", 1'b0);

    // Long request keeps HOLD until it drops.
    req = 2'b10;
    tick();
    bump_evt();
    for (int k = 0; k < 40; k++) begin
      check("long_out", 32'(out_reset), 32'h3);
      check("long_busy", 32'(busy), 32'h1);
      tick();
    end
    req = 2'b00;
    check("long_evt", 32'(event_count), 32'(exp_evt));
    release_seq("long", 1'b0);

    // Abort during RELEASE after sink 0 has dropped.
    req = 2'b01;
    tick();
    req = 2'b00;
    bump_evt();
    stretch_seq("abt1");
    repeat (5) tick();
    check("abt_mid_out", 32'(out_reset), 32'h2);
    req = 2'b10;
    tick();
    bump_evt();
    req = 2'b00;
    check("abt_out", 32'(out_reset), 32'h3);
    check("abt_done", 32'(done), 32'h0);
    check("abt_busy", 32'(busy), 32'h1);
    check("abt_evt", 32'(event_count), 32'(exp_evt));
    stretch_seq("abt2");
    release_seq("abt2", 1'b0);

    // Re-request in the DONE cycle.
    req = 2'b01;
    tick();
    req = 2'b00;
    bump_evt();
    stretch_seq("dn1");
    release_seq("dn1", 1'b1);
    stretch_seq("dn2");
    release_seq("dn2", 1'b0);

    // Saturation of the event counter.
    for (int e = 0; e < 300; e++) begin
      req = 2'b01;
      tick();
      req = 2'b00;
      bump_evt();
      for (int j = 0; j < 60; j++) begin
        if (!busy) break;
        tick();
      end
      check("sat_idle", 32'(busy), 32'h0);
    end
    check("sat_evt", 32'(event_count), 32'(exp_evt));
    check("sat_evt255", 32'(event_count), 32'd255);

    // Reset asserted in the middle of RELEASE.
    req = 2'b01;
    tick();
    req = 2'b00;
    bump_evt();
    stretch_seq("mrst");
    repeat (5) tick();
    check("mrst_mid_out", 32'(out_reset), 32'h2);
    reset = 1'b1;
    tick();
    check("mrst_out", 32'(out_reset), 32'h3);
    check("mrst_evt", 32'(event_count), 32'h0);
    check("mrst_busy", 32'(busy), 32'h1);
    check("mrst_done", 32'(done), 32'h0);
    reset   = 1'b0;
    exp_evt = 0;
    stretch_seq("mrst2");
    release_seq("mrst2", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
